code_lock_ctrl: RTL

Sequential code-entry controller that shares one 4-bit switch digit input across two entry steps and checks the entries against the stored two-digit BIAS code (default 2 then 9). Each press of ENTER captures one digit from SW. The block grants a timed OPEN window after a correct pair, counts failed attempts, and forces a timed lockout after too many failures. It sits between the board pushbutton/switch inputs and the unlock indicator LEDs.

---
 rtl/code_lock_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl -- two-digit sequential code-entry lock.
//
// One 4-bit switch input is shared by both entry steps; each rising edge of
// ENTER captures one digit. A correct pair opens a timed OPEN window. Wrong
// pairs are counted, and MAX_FAILS of them in a row force a timed lockout.
// The first-digit result is held in m1 and only judged after the second
// press, so a wrong first digit is never revealed early.
//
// Optional feature macro: CODE_LOCK_TIMEOUT_EN. When it is defined,
// TIMEOUT_CYCLES idle cycles in SECOND count as a failed attempt.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   ENTER    in   pushbutton level, already synchronized to clk
//   SW       in   [3:0] digit for the current entry
//   OPEN     out  high while UNLOCKED
//   LOCKOUT  out  high while LOCKED
//   STAGE    out  [1:0] 0 FIRST, 1 SECOND, 2 UNLOCKED, 3 LOCKED
//   FAILS    out  [1:0] consecutive failures, saturating at 3
module code_lock_ctrl #(
  parameter logic [3:0] FIRST_DIGIT    = 4'd2,
  parameter logic [3:0] SECOND_DIGIT   = 4'd9,
  parameter int         MAX_FAILS      = 3,
  parameter int         OPEN_CYCLES    = 20,
  parameter int         LOCKOUT_CYCLES = 50,
  parameter int         TIMEOUT_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENTER,
  input  logic [3:0] SW,
  output logic       OPEN,
  output logic       LOCKOUT,
  output logic [1:0] STAGE,
  output logic [1:0] FAILS
);

  localparam int MAX_OL  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_ALL = (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;
  // Fail count never exceeds MAX_FAILS; keep at least 2 bits for the FAILS view.
  localparam int FW_RAW  = $clog2(MAX_FAILS + 1);
  localparam int FW      = (FW_RAW < 2) ? 2 : FW_RAW;

  typedef enum logic [1:0] {
    S_FIRST    = 2'd0,
    S_SECOND   = 2'd1,
    S_UNLOCKED = 2'd2,
    S_LOCKED   = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [FW-1:0]   fails, fails_nx, fails_inc;
  logic            m1, m1_nx;
  logic            prev;
  logic            press;
  logic            fail_evt;

  // prev resets to 1 so a button held through reset release is not a press.
  assign press     = ENTER & ~prev;
  assign fails_inc = fails + FW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FIRST;
      cnt   <= '0;
      fails <= '0;
      m1    <= 1'b0;
      prev  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      fails <= fails_nx;
      m1    <= m1_nx;
      prev  <= ENTER;
    end
  end

  always_comb begin
    state_nx = state;
    fails_nx = fails;
    m1_nx    = m1;
    fail_evt = 1'b0;
    case (state)
      S_FIRST: begin
        if (press) begin
          m1_nx    = (SW == FIRST_DIGIT);
          state_nx = S_SECOND;
        end
      end
      S_SECOND: begin
        if (press) begin
          if (m1 && (SW == SECOND_DIGIT)) begin
            state_nx = S_UNLOCKED;
            fails_nx = '0;
          end else begin
            fail_evt = 1'b1;
          end
`ifdef CODE_LOCK_TIMEOUT_EN
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          // Idle too long: treated exactly like a wrong second digit.
          fail_evt = 1'b1;
`endif
        end
        if (fail_evt) begin
          fails_nx = fails_inc;
          state_nx = (int'(fails_inc) >= MAX_FAILS) ? S_LOCKED : S_FIRST;
        end
      end
      S_UNLOCKED: begin
        if (cnt == CW'(OPEN_CYCLES - 1)) state_nx = S_FIRST;
      end
      S_LOCKED: begin
        if (cnt == CW'(LOCKOUT_CYCLES - 1)) begin
          state_nx = S_FIRST;
          fails_nx = '0;
        end
      end
      default: state_nx = S_FIRST;
    endcase
  end

  // Shared window/timeout counter: cleared on every state change, counts only
  // in states that have a time limit.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state) begin
      cnt_nx = '0;
    end else begin
      case (state)
        S_UNLOCKED, S_LOCKED: cnt_nx = cnt + CW'(1);
`ifdef CODE_LOCK_TIMEOUT_EN
        S_SECOND:             cnt_nx = cnt + CW'(1);
`endif
        default:              cnt_nx = cnt;
      endcase
    end
  end

  assign OPEN    = (state == S_UNLOCKED);
  assign LOCKOUT = (state == S_LOCKED);
  assign STAGE   = state;
  assign FAILS   = (fails > FW'(3)) ? 2'd3 : fails[1:0];

endmodule
